// File: rtl/spi_ctrl_pkg.sv
// Shared constants, command word layout and FSM encoding for the SPI command controller.
package spi_ctrl_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned OPC_W    = 4;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned MAX_DW   = 16;
    localparam int unsigned MAX_REGS = 16;

    localparam int unsigned OPC_HI  = 31;
    localparam int unsigned OPC_LO  = 28;
    localparam int unsigned ADDR_HI = 27;
    localparam int unsigned ADDR_LO = 24;
    localparam int unsigned RSV_HI  = 23;
    localparam int unsigned RSV_LO  = 16;

    localparam logic [OPC_W-1:0] OPC_NOP    = 4'h0;
    localparam logic [OPC_W-1:0] OPC_WRITE  = 4'h1;
    localparam logic [OPC_W-1:0] OPC_STROBE = 4'h2;
    localparam logic [OPC_W-1:0] OPC_SEND   = 4'h3;
    localparam logic [OPC_W-1:0] OPC_CLEAR  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACTIVE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DECODE  = 3'd3,
        ST_WAIT_TX = 3'd4
    } state_e;

    // Captured command; data is held at full width and trimmed to DW at use.
    typedef struct packed {
        logic [OPC_W-1:0]  opc;
        logic [ADDR_W-1:0] addr;
        logic [MAX_DW-1:0] data;
    } cmd_t;

    // Saturating event counter increment.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // One bit per address value, set where the address selects an existing register.
    function automatic logic [MAX_REGS-1:0] addr_mask(input int unsigned n);
        logic [MAX_REGS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_REGS; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/spi_ss_sync.sv
// Slave-select synchronizer with registered rise/fall pulses aligned to the synced level.
module spi_ss_sync
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic SS,
    output logic ss_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;

    // Flop chain resets to deselected; edge pulses look one stage ahead so they
    // coincide with the first cycle of the new synced level.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            chain <= '1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], SS};
            rise  <= chain[SYNC_STAGES-2] & ~chain[SYNC_STAGES-1];
            fall  <= ~chain[SYNC_STAGES-2] & chain[SYNC_STAGES-1];
        end
    end

    assign ss_s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_cmd_ctrl.sv
// End-of-frame capture, command decode, config bank, strobes and downstream send port.
module spi_cmd_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned NREGS       = 16,
    parameter int unsigned DW          = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SETTLE      = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SS,
    input  logic [WORD_W-1:0]     byteRx,
    output logic [NREGS*DW-1:0]   regs_flat,
    output logic [NREGS-1:0]      strobe,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_W-1:0]     tx_addr,
    output logic [DW-1:0]         tx_data,
    output logic                  busy,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W-1:0]      ovr_cnt
);

    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [MAX_REGS-1:0] ADDR_OK = addr_mask(NREGS);

    state_e              state;
    state_e              next_state;
    cmd_t                cmd;
    logic [SET_W-1:0]    settle_cnt;
    logic                ss_s;
    logic                ss_rise;
    logic                ss_fall;
    logic                settle_done;
    logic                addr_ok;
    logic [MAX_REGS-1:0] addr_onehot;
    logic                cap_en;
    logic                do_frame;
    logic                do_write;
    logic                do_strobe;
    logic                do_send;
    logic                do_clear;
    logic                do_err;
    logic                do_ovr;
    logic                tx_done;
    logic                unused_rsvd;

    // The reserved field of the command word carries no meaning here.
    assign unused_rsvd = ^byteRx[RSV_HI:RSV_LO];

    spi_ss_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ss_sync (
        .CLK  (CLK),
        .RST  (RST),
        .SS   (SS),
        .ss_s (ss_s),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    assign settle_done = (settle_cnt == SET_W'(SETTLE - 1));
    assign addr_ok     = ADDR_OK[cmd.addr];
    assign addr_onehot = MAX_REGS'(1) << cmd.addr;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a rise seen in IDLE means the fall was missed.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (ss_rise) begin
                    next_state = ST_CAPTURE;
                end else if (ss_fall) begin
                    next_state = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) begin
                    next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (settle_done) begin
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                next_state = (cmd.opc == OPC_SEND) ? ST_WAIT_TX : ST_IDLE;
            end
            ST_WAIT_TX: begin
                if (tx_valid && tx_ready) begin
                    next_state = ss_s ? ST_IDLE : ST_ACTIVE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Control decode for the datapath, derived from the current state.
    always_comb begin
        cap_en    = 1'b0;
        do_frame  = 1'b0;
        do_write  = 1'b0;
        do_strobe = 1'b0;
        do_send   = 1'b0;
        do_clear  = 1'b0;
        do_err    = 1'b0;
        do_ovr    = 1'b0;
        tx_done   = 1'b0;
        case (state)
            ST_CAPTURE: begin
                cap_en = settle_done;
                do_ovr = ss_rise;
            end
            ST_DECODE: begin
                do_frame = 1'b1;
                do_ovr   = ss_rise;
                case (cmd.opc)
                    OPC_NOP:    ;
                    OPC_WRITE:  begin do_write = addr_ok;  do_err = ~addr_ok; end
                    OPC_STROBE: begin do_strobe = addr_ok; do_err = ~addr_ok; end
                    OPC_SEND:   do_send = 1'b1;
                    OPC_CLEAR:  do_clear = 1'b1;
                    default:    do_err = 1'b1;
                endcase
            end
            ST_WAIT_TX: begin
                do_ovr  = ss_rise;
                tx_done = tx_valid && tx_ready;
            end
            default: ;
        endcase
    end

    // Settle counter and word capture at the end of the settle window.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            settle_cnt <= '0;
            cmd        <= '0;
        end else begin
            if (state == ST_CAPTURE && !settle_done) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end else begin
                settle_cnt <= '0;
            end
            if (cap_en) begin
                cmd <= '{opc:  byteRx[OPC_HI:OPC_LO],
                         addr: byteRx[ADDR_HI:ADDR_LO],
                         data: MAX_DW'(byteRx[DW-1:0])};
            end
        end
    end

    // Config bank and single-cycle strobes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            regs_flat <= '0;
            strobe    <= '0;
        end else begin
            strobe <= do_strobe ? addr_onehot[NREGS-1:0] : '0;
            if (do_clear) begin
                regs_flat <= '0;
            end else if (do_write) begin
                for (int i = 0; i < int'(NREGS); i++) begin
                    if (cmd.addr == ADDR_W'(i)) begin
                        regs_flat[i*DW +: DW] <= cmd.data[DW-1:0];
                    end
                end
            end
        end
    end

    // Downstream send port: payload frozen while valid is held.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_valid <= 1'b0;
            tx_addr  <= '0;
            tx_data  <= '0;
        end else if (do_send) begin
            tx_valid <= 1'b1;
            tx_addr  <= cmd.addr;
            tx_data  <= cmd.data[DW-1:0];
        end else if (tx_done) begin
            tx_valid <= 1'b0;
        end
    end

    // Status: busy tracks the state register, counters saturate.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy      <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
            ovr_cnt   <= '0;
        end else begin
            busy <= (next_state != ST_IDLE) && (next_state != ST_ACTIVE);
            if (do_frame) begin
                frame_cnt <= sat_inc(frame_cnt);
            end
            if (do_err) begin
                err_cnt <= sat_inc(err_cnt);
            end
            if (do_ovr) begin
                ovr_cnt <= sat_inc(ovr_cnt);
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl with an 8-register bank to exercise address range checks.
module tb_spi_cmd_ctrl;

    localparam int unsigned NREGS = 8;
    localparam int unsigned DW    = 16;

    logic                CLK = 1'b0;
    logic                RST;
    logic                SS;
    logic [31:0]         byteRx;
    logic [NREGS*DW-1:0] regs_flat;
    logic [NREGS-1:0]    strobe;
    logic                tx_valid;
    logic                tx_ready;
    logic [3:0]          tx_addr;
    logic [DW-1:0]       tx_data;
    logic                busy;
    logic [7:0]          frame_cnt;
    logic [7:0]          err_cnt;
    logic [7:0]          ovr_cnt;

    int tests = 0;
    int fails = 0;
    int xfers = 0;
    logic [NREGS*DW-1:0] exp_regs;

    spi_cmd_ctrl #(
        .NREGS(NREGS), .DW(DW), .SYNC_STAGES(2), .SETTLE(2)
    ) dut (
        .CLK(CLK), .RST(RST), .SS(SS), .byteRx(byteRx),
        .regs_flat(regs_flat), .strobe(strobe),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_addr(tx_addr), .tx_data(tx_data),
        .busy(busy), .frame_cnt(frame_cnt), .err_cnt(err_cnt), .ovr_cnt(ovr_cnt)
    );

    always #5 CLK = ~CLK;

    // Count completed handshakes on the downstream port.
    always @(posedge CLK) begin
        if (!RST && tx_valid && tx_ready) xfers++;
    end

    // One SPI frame: SS low long enough to be seen, then released at a falling CLK edge.
    task automatic drive_frame(input logic [31:0] w);
        @(negedge CLK);
        byteRx = w;
        SS = 1'b0;
        repeat (6) @(negedge CLK);
        SS = 1'b1;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        edges(3);
        tests++; if (regs_flat !== '0) begin fails++; $display("FAIL reset_regs got %h exp 0", regs_flat); end
        tests++; if (strobe !== '0 || tx_valid !== 1'b0 || busy !== 1'b0) begin fails++;
            $display("FAIL reset_ctl got strobe=%h tx_valid=%b busy=%b exp 0", strobe, tx_valid, busy); end
        tests++; if ({frame_cnt, err_cnt, ovr_cnt} !== 24'h0) begin fails++;
            $display("FAIL reset_cnt got %h/%h/%h exp 0", frame_cnt, err_cnt, ovr_cnt); end
        @(negedge CLK);
        RST = 1'b0;
        edges(4);
        tests++; if (busy !== 1'b0 || regs_flat !== '0) begin fails++;
            $display("FAIL post_reset got busy=%b regs=%h exp 0", busy, regs_flat); end
    endtask

    task automatic test_write();
        drive_frame(32'h1300ABCD);
        edges(5);
        tests++; if (regs_flat !== '0) begin fails++; $display("FAIL write_early got %h exp 0", regs_flat); end
        edges(1);
        exp_regs[3*DW +: DW] = 16'hABCD;
        tests++; if (regs_flat !== exp_regs) begin fails++; $display("FAIL write_reg3 got %h exp %h", regs_flat, exp_regs); end
        tests++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL write_frame_cnt got %0d exp 1", frame_cnt); end
    endtask

    task automatic test_strobe();
        drive_frame(32'h25000000);
        edges(5);
        tests++; if (strobe !== 8'h00) begin fails++; $display("FAIL strobe_early got %h exp 00", strobe); end
        edges(1);
        tests++; if (strobe !== 8'h20) begin fails++; $display("FAIL strobe_pulse got %h exp 20", strobe); end
        edges(1);
        tests++; if (strobe !== 8'h00) begin fails++; $display("FAIL strobe_width got %h exp 00", strobe); end
        tests++; if (regs_flat !== exp_regs || frame_cnt !== 8'd2) begin fails++;
            $display("FAIL strobe_side got regs=%h cnt=%0d exp %h 2", regs_flat, frame_cnt, exp_regs); end
    endtask

    task automatic test_send_backpressure();
        int x0;
        logic bad;
        x0 = xfers;
        tx_ready = 1'b0;
        drive_frame(32'h3A001234);
        edges(5);
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL send_early got tx_valid=%b exp 0", tx_valid); end
        edges(1);
        tests++; if (tx_valid !== 1'b1 || tx_addr !== 4'hA || tx_data !== 16'h1234 || busy !== 1'b1) begin fails++;
            $display("FAIL send_present got v=%b a=%h d=%h busy=%b exp 1 a 1234 1", tx_valid, tx_addr, tx_data, busy); end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edges(1);
            if (tx_valid !== 1'b1 || tx_addr !== 4'hA || tx_data !== 16'h1234) bad = 1'b1;
        end
        tests++; if (bad !== 1'b0) begin fails++; $display("FAIL send_hold got unstable v=%b a=%h d=%h exp held", tx_valid, tx_addr, tx_data); end
        @(negedge CLK);
        tx_ready = 1'b1;
        edges(1);
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL send_drop got tx_valid=%b exp 0", tx_valid); end
        @(negedge CLK);
        tx_ready = 1'b0;
        edges(3);
        tests++; if (xfers - x0 !== 1 || busy !== 1'b0 || frame_cnt !== 8'd3) begin fails++;
            $display("FAIL send_count got xfers=%0d busy=%b cnt=%0d exp 1 0 3", xfers - x0, busy, frame_cnt); end
    endtask

    task automatic test_overrun();
        int x0;
        x0 = xfers;
        tx_ready = 1'b0;
        drive_frame(32'h3A001234);
        edges(6);
        tests++; if (tx_valid !== 1'b1) begin fails++; $display("FAIL ovr_pending got tx_valid=%b exp 1", tx_valid); end
        drive_frame(32'h1100FFFF);
        edges(8);
        tests++; if (ovr_cnt !== 8'd1) begin fails++; $display("FAIL ovr_cnt got %0d exp 1", ovr_cnt); end
        tests++; if (regs_flat !== exp_regs || frame_cnt !== 8'd4) begin fails++;
            $display("FAIL ovr_discard got regs=%h cnt=%0d exp %h 4", regs_flat, frame_cnt, exp_regs); end
        tests++; if (tx_valid !== 1'b1 || tx_data !== 16'h1234 || tx_addr !== 4'hA) begin fails++;
            $display("FAIL ovr_keep got v=%b a=%h d=%h exp 1 a 1234", tx_valid, tx_addr, tx_data); end
        @(negedge CLK);
        tx_ready = 1'b1;
        edges(1);
        @(negedge CLK);
        tx_ready = 1'b0;
        edges(2);
        tests++; if (xfers - x0 !== 1 || tx_valid !== 1'b0) begin fails++;
            $display("FAIL ovr_xfer got xfers=%0d v=%b exp 1 0", xfers - x0, tx_valid); end
    endtask

    task automatic test_errors();
        drive_frame(32'h70000000);
        edges(7);
        drive_frame(32'h19000001);
        edges(7);
        tests++; if (err_cnt !== 8'd2 || regs_flat !== exp_regs) begin fails++;
            $display("FAIL err_basic got err=%0d regs=%h exp 2 %h", err_cnt, regs_flat, exp_regs); end
        drive_frame(32'h17005555);
        edges(7);
        exp_regs[7*DW +: DW] = 16'h5555;
        tests++; if (regs_flat !== exp_regs || err_cnt !== 8'd2) begin fails++;
            $display("FAIL err_top_addr got regs=%h err=%0d exp %h 2", regs_flat, err_cnt, exp_regs); end
        drive_frame(32'h28000000);
        edges(6);
        tests++; if (strobe !== 8'h00) begin fails++; $display("FAIL err_strobe got %h exp 00", strobe); end
        edges(1);
        tests++; if (err_cnt !== 8'd3 || frame_cnt !== 8'd8) begin fails++;
            $display("FAIL err_strobe_cnt got err=%0d frame=%0d exp 3 8", err_cnt, frame_cnt); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) begin
            drive_frame(32'h70000000);
            edges(7);
        end
        tests++; if (err_cnt !== 8'hFF || frame_cnt !== 8'hFF) begin fails++;
            $display("FAIL sat got err=%h frame=%h exp ff ff", err_cnt, frame_cnt); end
        tests++; if (regs_flat !== exp_regs || ovr_cnt !== 8'd1) begin fails++;
            $display("FAIL sat_side got regs=%h ovr=%0d exp %h 1", regs_flat, ovr_cnt, exp_regs); end
    endtask

    task automatic test_clear();
        drive_frame(32'h10001111);
        edges(7);
        exp_regs[0 +: DW] = 16'h1111;
        tests++; if (regs_flat !== exp_regs) begin fails++; $display("FAIL clear_pre got %h exp %h", regs_flat, exp_regs); end
        drive_frame(32'hF0000000);
        edges(6);
        exp_regs = '0;
        tests++; if (regs_flat !== exp_regs) begin fails++; $display("FAIL clear_all got %h exp 0", regs_flat); end
    endtask

    task automatic test_reset_wait_tx();
        int x0;
        drive_frame(32'h15002222);
        edges(7);
        tests++; if (regs_flat[5*DW +: DW] !== 16'h2222) begin fails++;
            $display("FAIL rst_pre_write got %h exp 2222", regs_flat[5*DW +: DW]); end
        tx_ready = 1'b0;
        drive_frame(32'h3A001234);
        edges(6);
        @(negedge CLK);
        RST = 1'b1;
        SS = 1'b0;
        byteRx = 32'h1200BEEF;
        #1;
        tests++; if (tx_valid !== 1'b0 || regs_flat !== '0 || busy !== 1'b0) begin fails++;
            $display("FAIL rst_async got v=%b regs=%h busy=%b exp 0", tx_valid, regs_flat, busy); end
        tests++; if ({frame_cnt, err_cnt, ovr_cnt} !== 24'h0) begin fails++;
            $display("FAIL rst_async_cnt got %h/%h/%h exp 0", frame_cnt, err_cnt, ovr_cnt); end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        x0 = xfers;
        tx_ready = 1'b1;
        repeat (6) @(negedge CLK);
        SS = 1'b1;
        edges(6);
        tests++; if (regs_flat[2*DW +: DW] !== 16'hBEEF || frame_cnt !== 8'd1) begin fails++;
            $display("FAIL rst_ss_low got reg2=%h frame=%0d exp beef 1", regs_flat[2*DW +: DW], frame_cnt); end
        edges(3);
        tests++; if (xfers - x0 !== 0 || tx_valid !== 1'b0) begin fails++;
            $display("FAIL rst_send_lost got xfers=%0d v=%b exp 0 0", xfers - x0, tx_valid); end
        tx_ready = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        SS = 1'b1;
        byteRx = 32'h0;
        tx_ready = 1'b0;
        exp_regs = '0;
        test_reset();
        test_write();
        test_strobe();
        test_send_backpressure();
        test_overrun();
        test_errors();
        test_saturation();
        test_clear();
        test_reset_wait_tx();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
